// File: rtl/branch_history_predictor_if.sv
// Fetch-side lookup and execute-side training bundle
// for the branch history predictor.
interface branch_history_predictor_if;
    logic        lk_valid;
    logic [31:0] lk_pc;
    logic        flush;
    logic        pred_valid;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;

    modport master (
        output lk_valid, lk_pc, flush,
        output upd_valid, upd_pc, upd_taken, upd_target,
        input  pred_valid, pred_hit, pred_taken, pred_target
    );

    modport slave (
        input  lk_valid, lk_pc, flush,
        input  upd_valid, upd_pc, upd_taken, upd_target,
        output pred_valid, pred_hit, pred_taken, pred_target
    );
endinterface

// File: rtl/branch_history_predictor.sv
// Direct-mapped 2-bit counter branch predictor with target
// storage; one-cycle registered lookup, write-first training.
module branch_history_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8
) (
    input logic                        clk,
    input logic                        rst,
    branch_history_predictor_if.slave  bus
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];

    logic        pred_valid_q;
    logic        pred_hit_q;
    logic        pred_taken_q;
    logic [31:0] pred_target_q;

    logic [INDEX_BITS-1:0] l_idx;
    logic [TAG_BITS-1:0]   l_tag;
    logic [INDEX_BITS-1:0] u_idx;
    logic [TAG_BITS-1:0]   u_tag;

    assign l_idx = bus.lk_pc[INDEX_BITS+1:2];
    assign l_tag = bus.lk_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign u_idx = bus.upd_pc[INDEX_BITS+1:2];
    assign u_tag = bus.upd_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];

    logic unused_pc;
    assign unused_pc = ^{bus.lk_pc, bus.upd_pc};

    logic        u_hit;
    logic        u_write;
    logic [1:0]  u_ctr_n;
    logic [31:0] u_target_n;

    always_comb begin
        u_hit      = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        u_write    = bus.upd_valid && (u_hit || bus.upd_taken);
        u_ctr_n    = ctr_q[u_idx];
        u_target_n = target_q[u_idx];
        if (!u_hit) begin
            u_ctr_n    = 2'b10;
            u_target_n = bus.upd_target;
        end else if (bus.upd_taken) begin
            u_ctr_n    = (ctr_q[u_idx] == 2'b11) ? 2'b11 : ctr_q[u_idx] + 2'd1;
            u_target_n = bus.upd_target;
        end else begin
            u_ctr_n    = (ctr_q[u_idx] == 2'b00) ? 2'b00 : ctr_q[u_idx] - 2'd1;
        end
    end

    // A same-cycle write to the looked-up index is forwarded
    logic                fwd;
    logic                rd_valid;
    logic [TAG_BITS-1:0] rd_tag;
    logic [1:0]          rd_ctr;
    logic [31:0]         rd_target;
    logic                l_hit;
    logic                l_accept;

    always_comb begin
        fwd       = u_write && (u_idx == l_idx);
        rd_valid  = fwd ? 1'b1       : valid_q[l_idx];
        rd_tag    = fwd ? u_tag      : tag_q[l_idx];
        rd_ctr    = fwd ? u_ctr_n    : ctr_q[l_idx];
        rd_target = fwd ? u_target_n : target_q[l_idx];
        l_hit     = rd_valid && (rd_tag == l_tag);
        l_accept  = bus.lk_valid && !bus.flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                ctr_q[i]    <= 2'b01;
                target_q[i] <= '0;
            end
            pred_valid_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            if (u_write) begin
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                ctr_q[u_idx]    <= u_ctr_n;
                target_q[u_idx] <= u_target_n;
            end
            pred_valid_q  <= l_accept;
            pred_hit_q    <= l_accept && l_hit;
            pred_taken_q  <= l_accept && l_hit && rd_ctr[1];
            pred_target_q <= (l_accept && l_hit) ? rd_target : 32'd0;
        end
    end

    assign bus.pred_valid  = pred_valid_q;
    assign bus.pred_hit    = pred_hit_q;
    assign bus.pred_taken  = pred_taken_q;
    assign bus.pred_target = pred_target_q;
endmodule
